frame_store_writer: RTL

- Captures one full active-area video frame into the frame BRAM as packed RGB332 bytes on request.
- Writer side of the stored-frame path. The display pixel selector reads this BRAM while store_frame is set and unpacks bytes as {R[7:5],G[7:5],B[7:6]}.
- Sits after the enhancement/HSV->RGB chain. Consumes the delayed pixel plus its aligned hcount/vcount/blank/vsync.

---
 rtl/frame_store_writer_pkg.sv | 47 ++++
 rtl/frame_store_writer_pack.sv | 38 +++
 rtl/frame_store_writer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/frame_store_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_store_writer_pkg
// Shared definitions for the stored-frame path: default active-area size,
// RGB888 source field positions, RGB332 packed field positions (also used by
// the reader-side unpack), the writer FSM state encoding and the packing
// helper function.
// -----------------------------------------------------------------------------
package frame_store_writer_pkg;

    // Default active area captured into the frame BRAM
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 400;

    // Field widths kept in the packed RGB332 byte
    localparam int R_BITS = 3;
    localparam int G_BITS = 3;
    localparam int B_BITS = 2;

    // MSB of each colour in the RGB888 {R,G,B} input word
    localparam int R_MSB = 23;
    localparam int G_MSB = 15;
    localparam int B_MSB = 7;

    // LSB of each colour inside the packed byte {R[7:5],G[7:5],B[7:6]}
    localparam int R332_LSB = 5;
    localparam int G332_LSB = 2;
    localparam int B332_LSB = 0;

    // Writer FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } fsw_state_t;

    // Keep the top bits of each channel
    function automatic logic [7:0] pack_rgb332(input logic [23:0] rgb);
        logic [7:0] packed_px;
        packed_px = '0;
        packed_px[R332_LSB +: R_BITS] = rgb[R_MSB -: R_BITS];
        packed_px[G332_LSB +: G_BITS] = rgb[G_MSB -: G_BITS];
        packed_px[B332_LSB +: B_BITS] = rgb[B_MSB -: B_BITS];
        return packed_px;
    endfunction

endpackage

// File: rtl/frame_store_writer_pack.sv
// -----------------------------------------------------------------------------
// rgb332_pack
// Registered RGB888 -> RGB332 packer. One clock of latency so the packed byte
// lines up with the registered write enable and address of the writer.
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   pixel_in   RGB888 {R,G,B}
//   pixel_out  packed {R[7:5],G[7:5],B[7:6]}, one cycle after pixel_in
// -----------------------------------------------------------------------------
module rgb332_pack
    import frame_store_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_in,
    output logic [7:0]  pixel_out
);

    logic [7:0] pix_d;
    logic [7:0] pix_q;

    // Pack the incoming pixel every cycle; the writer's bram_we qualifies it
    always_comb begin
        pix_d = pack_rgb332(pixel_in);
    end

    // Pipeline register matching the write-enable latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pixel_out = pix_q;

endmodule

// File: rtl/frame_store_writer.sv
// -----------------------------------------------------------------------------
// frame_store_writer
// Captures one full active-area frame into the frame BRAM as RGB332 bytes when
// requested. The capture starts at (0,0) of the first frame that begins after
// a genuine vsync falling edge seen while armed, writes every in-window pixel
// with a running address, and marks the stored frame valid when complete.
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   capture_req       one-cycle request to capture the next full frame
//   clear_frame       one-cycle request to invalidate the stored frame
//   pixel_in          RGB888 pixel aligned with hcount/vcount/blank
//   hcount, vcount    raster position of pixel_in
//   blank, vsync      blanking (high outside visible) and active-low vsync
//   bram_addr/din/we  BRAM write port, one cycle after the sampled pixel
//   busy              high while ARMED or CAPTURE
//   done              one-cycle pulse after the last pixel write
//   frame_valid       BRAM holds a complete captured frame
// -----------------------------------------------------------------------------
module frame_store_writer
    import frame_store_writer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_req,
    input  logic              clear_frame,
    input  logic [23:0]       pixel_in,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              blank,
    input  logic              vsync,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic              frame_valid
);

    localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    fsw_state_t        state_q, state_d;
    logic              seen_vs_q, seen_vs_d;
    logic              vs_hist_q, vs_hist_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fv_q, fv_d;

    logic in_win;
    logic vs_fall;
    logic start_hit;
    logic write_now;
    logic last_write;

    assign in_win  = (hcount < H_LIM) && (vcount < V_LIM) && !blank;
    assign vs_fall = vs_hist_q && !vsync;

    // The frame origin only starts a capture once a real vsync fall was seen,
    // and that origin pixel is written in the same cycle as the transition.
    assign start_hit  = (state_q == ARMED) && seen_vs_q
                        && (hcount == '0) && (vcount == '0);
    assign write_now  = ((state_q == CAPTURE) || start_hit) && in_win;
    assign last_write = write_now && (cnt_q == LAST_ADDR);

    // State register and all other flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            seen_vs_q <= 1'b0;
            vs_hist_q <= 1'b1;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_vs_q <= seen_vs_d;
            vs_hist_q <= vs_hist_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fv_q      <= fv_d;
        end
    end

    // Next-state logic; requests outside IDLE are dropped, never queued
    always_comb begin
        state_d   = state_q;
        seen_vs_d = seen_vs_q;
        vs_hist_d = vsync;
        case (state_q)
            IDLE: begin
                seen_vs_d = 1'b0;
                if (capture_req) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (vs_fall) begin
                    seen_vs_d = 1'b1;
                end
                if (start_hit) begin
                    state_d = last_write ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (last_write) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: write pipeline, address counter and status flags.
    // The counter sits at 0 until the capture starts and only advances on writes.
    always_comb begin
        we_d      = write_now;
        wr_addr_d = write_now ? cnt_q : wr_addr_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (write_now) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
        done_d = (state_q == DONE);
        fv_d   = fv_q;
        if ((state_q == IDLE) && capture_req) begin
            fv_d = 1'b0;
        end
        if (clear_frame) begin
            fv_d = 1'b0;
        end
        if (state_q == DONE) begin
            fv_d = 1'b1;
        end
    end

    rgb332_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .pixel_in  (pixel_in),
        .pixel_out (bram_din)
    );

    assign bram_addr   = wr_addr_q;
    assign bram_we     = we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_valid = fv_q;

endmodule
